metronome_beat_scheduler: RTL and testbench
===========================================

# metronome_beat_scheduler

- Sequences the metronome datapath behind the AXI4-Lite register slave.
- Takes the decoded register contents: enable, beat period, tone length, beats per bar, tone divider.
- Produces cycle-accurate beat and bar strobes, a running beat index, and the gated square-wave tone that drives the buzzer pin.
- Configuration writes are shadowed and take effect only on beat boundaries, so register updates never truncate or stretch a beat.

## Interface
- CNT_W, 32, width of period/tone-length counters
- BEAT_W, 4, width of beats-per-bar and beat index
- DIV_W, 16, width of tone half-period dividers
- Clock and reset: one clock; reset is synchronous and active-high.
- ACLK  in  1  system clock
- ARESET  in  1  synchronous active-high reset
- cfg_enable  in  1  run request (reg0 bit0), level
- cfg_load  in  1  one-cycle strobe on any config register write
- cfg_period  in  CNT_W  clocks per beat
- cfg_tone_len  in  CNT_W  clocks of tone per beat
- cfg_beats  in  BEAT_W  beats per bar
- cfg_tone_div  in  DIV_W  tone half-period in clocks
- cfg_accent_div  in  DIV_W  accent tone half-period (beat 0)
- beat_pulse  out  1  one-cycle strobe at each beat start
- bar_pulse  out  1  one-cycle strobe when beat_idx returns to 0
- beat_idx  out  BEAT_W  current beat within bar
- tone_out  out  1  gated square wave to buzzer
- busy  out  1  high in any state except IDLE
- cfg_err  out  1  sticky: last applied config was clamped

## Operation
- States: IDLE, TONE, GAP.
- IDLE → TONE when cfg_enable=1. On entry:
  - latch shadow config
  - cnt=0, beat_idx=0
  - beat_pulse=1, bar_pulse=1
- Period counter cnt runs 0..P-1.
  - TONE while cnt<T; GAP while cnt≥T.
  - T=0 enters GAP directly: beat_pulse still fires, tone_out stays 0.
- Beat boundary (cnt==P-1):
  - cnt←0; beat_idx←(beat_idx==B-1)?0:beat_idx+1
  - beat_pulse=1; bar_pulse=1 when new beat_idx==0
  - state→TONE (or GAP if T=0)
- cfg_load sets a pending flag. Pending config is copied to the shadow registers at the next beat boundary or IDLE exit, then the flag clears. A cfg_load in the same cycle as a boundary is applied at that boundary.
- Clamping, applied when the shadow is loaded:
  - P<2 → P=2
  - T≥P → T=P-1
  - B=0 → B=1
  - div=0 → 1
  - cfg_err←1 if any clamp fired, else 0.
- B shrinking below the current beat_idx+1 on load: beat_idx wraps to 0 at that boundary with bar_pulse.
- cfg_enable=0 in any state → IDLE next cycle. The beat is abandoned, counters are cleared, and tone_out=0.
- ARESET dominates everything, including mid-beat.

## Timing
- Reset values: state IDLE, all outputs 0, pending=0, shadow config = P 2, T 1, B 1, div 1.
- Start latency: cfg_enable sampled high at edge k → beat_pulse, bar_pulse, busy and tone_out all high after edge k+1.
- Beat strobes are exactly P cycles apart. beat_idx changes in the same cycle as beat_pulse.
- tone_out is 1 on TONE entry and toggles every div cycles while in TONE. It is forced to 0 the cycle GAP is entered; the divider restarts every beat.
- Stop latency: cfg_enable low at edge k → busy=0 and tone_out=0 after edge k+1.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- METRONOME_ACCENT_EN defined: beat 0 of each bar uses cfg_accent_div (shadowed and clamped like cfg_tone_div).
- Undefined: every beat uses cfg_tone_div. cfg_accent_div remains a port but is ignored.

## Structure
- Package metronome_pkg holds:
  - state enum (IDLE/TONE/GAP)
  - reset/minimum constants (P_MIN=2, B_MIN=1, DIV_MIN=1)
  - packed cfg_t struct (period, tone_len, beats, tone_div, accent_div) used for live and shadow config
- Sub-module metronome_tone_gen: enable, div input, tone_out. Divider counter that restarts high on enable rise and outputs 0 when disabled.

## Test plan
- Basic run: P=10, T=4, B=4, div=1, enable at cycle 0.
  - beat_pulse at cycles 1, 11, 21, 31, 41; bar_pulse at 1 and 41; beat_idx 0,1,2,3,0.
  - tone_out 1,0,1,0 for cycles 1–4, then 0 for cycles 5–10.
- Shadowed update: mid-beat cfg_load with P=6.
  - Current beat still lasts 10 cycles; following beats are 6 apart.
  - cfg_load coincident with a boundary takes effect at that boundary.
- Clamping: P=1, T=5, B=0, div=0.
  - Beats every 2 cycles, tone 1 cycle, beat_idx stuck at 0, bar_pulse every beat, cfg_err=1.
  - A clean load clears cfg_err at the next boundary.
- Stop/reset mid-beat: drop cfg_enable at cnt=3.
  - busy=0 and tone_out=0 next cycle.
  - Re-enable restarts with beat_idx=0 and bar_pulse.
  - ARESET at cnt=5 gives the same outputs as the reset values.
- Accent (METRONOME_ACCENT_EN): accent_div=3, tone_div=1, T=6.
  - Beat 0 tone_out is 1,1,1,0,0,0; beat 1 is 1,0,1,0,1,0.
  - Without the macro, both beats are 1,0,1,0,1,0.
- Beats shrink: B changes 8→2 while beat_idx=5. At the next boundary beat_idx=0 and bar_pulse=1.

Source files
------------

// File: rtl/metronome_pkg.sv
// Metronome shared types, reset constants and config clamping.
// Optional feature macro: METRONOME_ACCENT_EN (accent tone on beat 0).
package metronome_pkg;

  localparam int CFG_CNT_W  = 32;
  localparam int CFG_BEAT_W = 4;
  localparam int CFG_DIV_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TONE,
    ST_GAP
  } state_t;

  localparam logic [CFG_CNT_W-1:0]  P_MIN   = CFG_CNT_W'(2);
  localparam logic [CFG_CNT_W-1:0]  T_RST   = CFG_CNT_W'(1);
  localparam logic [CFG_BEAT_W-1:0] B_MIN   = CFG_BEAT_W'(1);
  localparam logic [CFG_DIV_W-1:0]  DIV_MIN = CFG_DIV_W'(1);

  typedef struct packed {
    logic [CFG_CNT_W-1:0]  period;
    logic [CFG_CNT_W-1:0]  tone_len;
    logic [CFG_BEAT_W-1:0] beats;
    logic [CFG_DIV_W-1:0]  tone_div;
    logic [CFG_DIV_W-1:0]  accent_div;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    period:     P_MIN,
    tone_len:   T_RST,
    beats:      B_MIN,
    tone_div:   DIV_MIN,
    accent_div: DIV_MIN
  };

  // Force a config into the legal range.
  // Tone length is limited against the already-clamped period
  // so every beat keeps at least one silent cycle.
  function automatic cfg_t cfg_clamp(cfg_t c);
    cfg_t r;
    r = c;
    if (c.period < P_MIN)
      r.period = P_MIN;
    if (c.tone_len >= r.period)
      r.tone_len = r.period - CFG_CNT_W'(1);
    if (c.beats == '0)
      r.beats = B_MIN;
    if (c.tone_div == '0)
      r.tone_div = DIV_MIN;
    if (c.accent_div == '0)
      r.accent_div = DIV_MIN;
    return r;
  endfunction

  // True when clamping changes a field that is in use.
  // The accent divider only counts when the accent tone exists.
  function automatic logic cfg_err_of(cfg_t c, logic accent_en);
    cfg_t m;
    m = c;
    if (!accent_en)
      m.accent_div = DIV_MIN;
    return cfg_clamp(m) != m;
  endfunction

endpackage

// File: rtl/metronome_tone_gen.sv
// Square-wave divider for the buzzer tone.
// Starts high on enable rise, holds low while disabled.
module metronome_tone_gen
  import metronome_pkg::*;
#(
  parameter int DIV_W = CFG_DIV_W
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tone
);

  logic             r_en_d;
  logic             r_tone;
  logic [DIV_W-1:0] r_cnt;

  // Half-period counter; restarts high on every enable rise.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_en_d <= 1'b0;
      r_tone <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_en_d <= i_en;
      if (!i_en) begin
        r_tone <= 1'b0;
        r_cnt  <= '0;
      end else if (!r_en_d) begin
        r_tone <= 1'b1;
        r_cnt  <= '0;
      end else if (r_cnt == i_div - DIV_W'(1)) begin
        r_tone <= ~r_tone;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign o_tone = r_tone;

endmodule

// File: rtl/metronome_beat_scheduler.sv
// Beat/bar sequencer with shadowed config and gated tone.
// Optional feature macro: METRONOME_ACCENT_EN (accent tone on beat 0).
module metronome_beat_scheduler
  import metronome_pkg::*;
#(
  parameter int CNT_W  = CFG_CNT_W,
  parameter int BEAT_W = CFG_BEAT_W,
  parameter int DIV_W  = CFG_DIV_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_enable,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_tone_len,
  input  logic [BEAT_W-1:0] cfg_beats,
  input  logic [DIV_W-1:0]  cfg_tone_div,
  input  logic [DIV_W-1:0]  cfg_accent_div,
  output logic              beat_pulse,
  output logic              bar_pulse,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              tone_out,
  output logic              busy,
  output logic              cfg_err
);

`ifdef METRONOME_ACCENT_EN
  localparam logic ACCENT_EN = 1'b1;
`else
  localparam logic ACCENT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0] r_idx;
  cfg_t              r_shadow;
  logic              r_pending;
  logic              r_err;
  logic              r_beat;
  logic              r_bar;
  logic              r_busy;

  state_t            w_state_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic [BEAT_W-1:0] w_idx_n;
  logic [BEAT_W:0]   w_idx_inc;
  cfg_t              w_live;
  cfg_t              w_cfg_n;
  logic              w_err_n;
  logic              w_pend;
  logic              w_pending_n;
  logic              w_boundary;
  logic              w_start;
  logic              w_apply;
  logic              w_beat_n;
  logic              w_bar_n;
  logic              w_tone_en;
  logic [DIV_W-1:0]  w_div;

  // Shadow update decision and beat sequencing.
  always_comb begin
    w_live = '{
      period:     cfg_period,
      tone_len:   cfg_tone_len,
      beats:      cfg_beats,
      tone_div:   cfg_tone_div,
      accent_div: cfg_accent_div
    };
    w_pend     = r_pending | cfg_load;
    w_boundary = (r_state != ST_IDLE) &&
                 (r_cnt == r_shadow.period - CNT_ONE);
    w_start    = (r_state == ST_IDLE) && cfg_enable;
    w_apply    = w_pend && cfg_enable &&
                 (w_start || w_boundary);
    w_cfg_n     = w_apply ? cfg_clamp(w_live) : r_shadow;
    w_err_n     = w_apply ? cfg_err_of(w_live, ACCENT_EN)
                          : r_err;
    w_pending_n = w_apply ? 1'b0 : w_pend;
    w_idx_inc   = {1'b0, r_idx} + (BEAT_W+1)'(1);
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_idx_n     = r_idx;
    w_beat_n    = 1'b0;
    w_bar_n     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cfg_enable) begin
          w_state_n = (w_cfg_n.tone_len == '0) ? ST_GAP
                                               : ST_TONE;
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_beat_n  = 1'b1;
          w_bar_n   = 1'b1;
        end
      end
      default: begin
        if (!cfg_enable) begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
          w_idx_n   = '0;
        end else if (w_boundary) begin
          w_cnt_n  = '0;
          w_idx_n  = (w_idx_inc >= {1'b0, w_cfg_n.beats})
                     ? '0 : w_idx_inc[BEAT_W-1:0];
          w_beat_n = 1'b1;
          w_bar_n  = (w_idx_n == '0);
          w_state_n = (w_cfg_n.tone_len == '0) ? ST_GAP
                                               : ST_TONE;
        end else begin
          w_cnt_n   = r_cnt + CNT_ONE;
          w_state_n = (w_cnt_n < r_shadow.tone_len) ? ST_TONE
                                                    : ST_GAP;
        end
      end
    endcase
  end

  // State, counters, shadow config and registered strobes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shadow  <= CFG_RST;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_beat    <= 1'b0;
      r_bar     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_idx     <= w_idx_n;
      r_shadow  <= w_cfg_n;
      r_pending <= w_pending_n;
      r_err     <= w_err_n;
      r_beat    <= w_beat_n;
      r_bar     <= w_bar_n;
      r_busy    <= (w_state_n != ST_IDLE);
    end
  end

  assign w_tone_en = (w_state_n == ST_TONE);
  assign w_div = (ACCENT_EN && r_idx == '0)
               ? r_shadow.accent_div
               : r_shadow.tone_div;

  metronome_tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .i_en   (w_tone_en),
    .i_div  (w_div),
    .o_tone (tone_out)
  );

  assign beat_pulse = r_beat;
  assign bar_pulse  = r_bar;
  assign beat_idx   = r_idx;
  assign busy       = r_busy;
  assign cfg_err    = r_err;

endmodule

// File: tb/tb_metronome_beat_scheduler.sv
// Directed bench for metronome_beat_scheduler.
// Honours METRONOME_ACCENT_EN for the accent expectations.
module tb_metronome_beat_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_enable;
  logic        cfg_load;
  logic [31:0] cfg_period;
  logic [31:0] cfg_tone_len;
  logic [3:0]  cfg_beats;
  logic [15:0] cfg_tone_div;
  logic [15:0] cfg_accent_div;
  logic        beat_pulse;
  logic        bar_pulse;
  logic [3:0]  beat_idx;
  logic        tone_out;
  logic        busy;
  logic        cfg_err;

  int n_vec = 0;
  int n_bad = 0;
  int n;
  int e0[6];
  int e1[6];

  always #5 ACLK = ~ACLK;

  metronome_beat_scheduler dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .cfg_enable     (cfg_enable),
    .cfg_load       (cfg_load),
    .cfg_period     (cfg_period),
    .cfg_tone_len   (cfg_tone_len),
    .cfg_beats      (cfg_beats),
    .cfg_tone_div   (cfg_tone_div),
    .cfg_accent_div (cfg_accent_div),
    .beat_pulse     (beat_pulse),
    .bar_pulse      (bar_pulse),
    .beat_idx       (beat_idx),
    .tone_out       (tone_out),
    .busy           (busy),
    .cfg_err        (cfg_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cfg(input int p, input int t,
                         input int b, input int d,
                         input int a);
    cfg_period     = 32'(p);
    cfg_tone_len   = 32'(t);
    cfg_beats      = 4'(b);
    cfg_tone_div   = 16'(d);
    cfg_accent_div = 16'(a);
  endtask

  task automatic wait_beat(input int max, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (beat_pulse !== 1'b1 && cnt < max);
    if (beat_pulse !== 1'b1)
      check("beat_timeout", 32'(beat_pulse), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_beat"}, 32'(beat_pulse), 32'd0);
    check({tag, "_bar"},  32'(bar_pulse),  32'd0);
    check({tag, "_idx"},  32'(beat_idx),   32'd0);
    check({tag, "_tone"}, 32'(tone_out),   32'd0);
    check({tag, "_busy"}, 32'(busy),       32'd0);
    check({tag, "_err"},  32'(cfg_err),    32'd0);
  endtask

  initial begin
    ARESET     = 1'b1;
    cfg_enable = 1'b0;
    cfg_load   = 1'b0;
    set_cfg(10, 4, 4, 1, 1);
    step();
    step();
    check_all_zero("rst");
    ARESET = 1'b0;

    // basic run
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    cfg_enable = 1'b1;
    step();
    check("start_busy", 32'(busy), 32'd1);
    check("start_err", 32'(cfg_err), 32'd0);
    for (int c = 1; c <= 41; c++) begin
      int ph;
      ph = (c - 1) % 10;
      check("b_beat", 32'(beat_pulse), 32'(ph == 0));
      check("b_bar", 32'(bar_pulse),
            32'((c - 1) % 40 == 0));
      check("b_idx", 32'(beat_idx), 32'(((c - 1) / 10) % 4));
      check("b_tone", 32'(tone_out),
            32'(ph < 4 && ph % 2 == 0));
      if (c < 41) step();
    end

    // shadowed period update mid-beat
    step(); step(); step();
    set_cfg(6, 4, 4, 1, 1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    wait_beat(20, n);
    check("shd_old_len", 32'(n), 32'd6);
    wait_beat(20, n);
    check("shd_new_p", 32'(n), 32'd6);

    // load coincident with the boundary
    for (int i = 0; i < 5; i++) step();
    set_cfg(8, 4, 4, 1, 1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("coinc_pulse", 32'(beat_pulse), 32'd1);
    wait_beat(20, n);
    check("coinc_p8", 32'(n), 32'd8);

    // clamping
    set_cfg(1, 5, 0, 0, 1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    wait_beat(20, n);
    check("clm_err", 32'(cfg_err), 32'd1);
    check("clm_bar0", 32'(bar_pulse), 32'd1);
    check("clm_tone0", 32'(tone_out), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("clm_beat", 32'(beat_pulse), 32'(k % 2 == 0));
      check("clm_bar", 32'(bar_pulse), 32'(k % 2 == 0));
      check("clm_tone", 32'(tone_out), 32'(k % 2 == 0));
      check("clm_idx", 32'(beat_idx), 32'd0);
      check("clm_err_k", 32'(cfg_err), 32'd1);
    end
    set_cfg(10, 4, 4, 1, 1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("cln_wait", 32'(cfg_err), 32'd1);
    step();
    check("cln_beat", 32'(beat_pulse), 32'd1);
    check("cln_err", 32'(cfg_err), 32'd0);
    check("cln_idx", 32'(beat_idx), 32'd1);
    check("cln_bar", 32'(bar_pulse), 32'd0);

    // stop mid-beat, restart, reset mid-beat
    step(); step(); step();
    cfg_enable = 1'b0;
    step();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_tone", 32'(tone_out), 32'd0);
    check("stop_idx", 32'(beat_idx), 32'd0);
    cfg_enable = 1'b1;
    step();
    check("re_beat", 32'(beat_pulse), 32'd1);
    check("re_bar", 32'(bar_pulse), 32'd1);
    check("re_idx", 32'(beat_idx), 32'd0);
    check("re_tone", 32'(tone_out), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    ARESET = 1'b1;
    step();
    check_all_zero("mrst");
    ARESET = 1'b0;
    step();
    check("rst_start", 32'(beat_pulse), 32'd1);
    wait_beat(20, n);
    check("rst_shadow_p", 32'(n), 32'd2);

    // accent
    cfg_enable = 1'b0;
    step();
    set_cfg(10, 6, 2, 1, 3);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    cfg_enable = 1'b1;
`ifdef METRONOME_ACCENT_EN
    e0 = '{1, 1, 1, 0, 0, 0};
`else
    e0 = '{1, 0, 1, 0, 1, 0};
`endif
    e1 = '{1, 0, 1, 0, 1, 0};
    step();
    check("acc_b0", 32'(beat_pulse), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("acc_t0", 32'(tone_out), 32'(e0[k]));
      step();
    end
    check("acc_gap", 32'(tone_out), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("acc_b1", 32'(beat_pulse), 32'd1);
    check("acc_idx1", 32'(beat_idx), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("acc_t1", 32'(tone_out), 32'(e1[k]));
      step();
    end

    // beats shrink below current index
    cfg_enable = 1'b0;
    step();
    set_cfg(4, 1, 8, 1, 1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    cfg_enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) wait_beat(10, n);
    check("shr_idx5", 32'(beat_idx), 32'd5);
    step();
    set_cfg(4, 1, 2, 1, 1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    wait_beat(10, n);
    check("shr_idx0", 32'(beat_idx), 32'd0);
    check("shr_bar", 32'(bar_pulse), 32'd1);
    wait_beat(10, n);
    check("shr_idx1", 32'(beat_idx), 32'd1);
    check("shr_bar1", 32'(bar_pulse), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
